// File: rtl/chipid_fetch_if.sv
// Avalon-MM read-only link between chipid_fetch (master) and the chip-ID slave.
interface chipid_fetch_if;
  logic        m_address;
  logic        m_read;
  logic [31:0] m_readdata;
  logic        m_waitrequest;

  modport master (
    output m_address,
    output m_read,
    input  m_readdata,
    input  m_waitrequest
  );

  modport slave (
    input  m_address,
    input  m_read,
    output m_readdata,
    output m_waitrequest
  );
endinterface

// File: rtl/chipid_fetch.sv
// Fetches the 64-bit chip ID (low word at address 0, high word at address 1) and holds it.
// Optional feature macro: CHIPID_FETCH_ZERO_RETRY_EN (retry while the slave returns an all-zero ID).
module chipid_fetch #(
  parameter bit          AUTO_START   = 1'b1,
  parameter int unsigned WAIT_TIMEOUT = 1024,
  parameter int unsigned RETRY_LIMIT  = 15,
  parameter int unsigned RETRY_DELAY  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  chipid_fetch_if.master       bus,
  output logic [63:0]          chip_id,
  output logic                 chip_id_valid,
  output logic                 busy,
  output logic                 error
);

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
`ifdef CHIPID_FETCH_ZERO_RETRY_EN
    DELAY,
`endif
    DONE,
    FAIL
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(WAIT_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        auto_pend;
  logic [15:0] wait_cnt, wait_nxt;
  logic [31:0] lo_reg;
  logic        lo_ld, id_ld, go;

`ifdef CHIPID_FETCH_ZERO_RETRY_EN
  localparam logic [7:0]  RETRY_MAX = 8'(RETRY_LIMIT);
  localparam logic [15:0] DLY_LAST  = 16'(RETRY_DELAY - 1);
  logic [7:0]  retry_cnt, retry_nxt;
  logic [15:0] dly_cnt, dly_nxt;
`else
  logic unused_retry_cfg;
  assign unused_retry_cfg = (RETRY_LIMIT != 0) ^ (RETRY_DELAY != 0);
`endif

  // AUTO_START makes the first cycle after reset behave like a start pulse.
  assign go = start | auto_pend;

  always_comb begin
    state_nxt = state;
    wait_nxt  = '0;
    lo_ld     = 1'b0;
    id_ld     = 1'b0;
`ifdef CHIPID_FETCH_ZERO_RETRY_EN
    retry_nxt = retry_cnt;
    dly_nxt   = dly_cnt;
`endif
    case (state)
      IDLE, DONE, FAIL: begin
        if (go) begin
          state_nxt = RD_LO;
`ifdef CHIPID_FETCH_ZERO_RETRY_EN
          retry_nxt = '0;
`endif
        end
      end
      RD_LO: begin
        if (!bus.m_waitrequest) begin
          lo_ld     = 1'b1;
          state_nxt = RD_HI;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = FAIL;
        end else begin
          wait_nxt = wait_cnt + 16'd1;
        end
      end
      RD_HI: begin
        if (!bus.m_waitrequest) begin
          id_ld = 1'b1;
`ifdef CHIPID_FETCH_ZERO_RETRY_EN
          if ({bus.m_readdata, lo_reg} != 64'd0) begin
            state_nxt = DONE;
          end else if (retry_cnt < RETRY_MAX) begin
            state_nxt = DELAY;
            retry_nxt = retry_cnt + 8'd1;
            dly_nxt   = DLY_LAST;
          end else begin
            state_nxt = FAIL;
          end
`else
          state_nxt = DONE;
`endif
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = FAIL;
        end else begin
          wait_nxt = wait_cnt + 16'd1;
        end
      end
`ifdef CHIPID_FETCH_ZERO_RETRY_EN
      DELAY: begin
        if (dly_cnt == 16'd0) state_nxt = RD_LO;
        else                  dly_nxt   = dly_cnt - 16'd1;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // All outputs are registered from the next-state decode so the slave inputs never reach them combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      auto_pend     <= AUTO_START;
      wait_cnt      <= '0;
      bus.m_read    <= 1'b0;
      bus.m_address <= 1'b0;
      chip_id       <= '0;
      chip_id_valid <= 1'b0;
      busy          <= 1'b0;
      error         <= 1'b0;
`ifdef CHIPID_FETCH_ZERO_RETRY_EN
      retry_cnt     <= '0;
      dly_cnt       <= '0;
`endif
    end else begin
      state         <= state_nxt;
      auto_pend     <= 1'b0;
      wait_cnt      <= wait_nxt;
      bus.m_read    <= (state_nxt == RD_LO) || (state_nxt == RD_HI);
      bus.m_address <= (state_nxt == RD_HI);
      chip_id_valid <= (state_nxt == DONE);
      error         <= (state_nxt == FAIL);
`ifdef CHIPID_FETCH_ZERO_RETRY_EN
      busy          <= (state_nxt == RD_LO) || (state_nxt == RD_HI) || (state_nxt == DELAY);
      retry_cnt     <= retry_nxt;
      dly_cnt       <= dly_nxt;
`else
      busy          <= (state_nxt == RD_LO) || (state_nxt == RD_HI);
`endif
      if (id_ld) chip_id <= {bus.m_readdata, lo_reg};
    end
  end

  always_ff @(posedge clk) begin
    if (lo_ld && !reset) lo_reg <= bus.m_readdata;
  end

endmodule

// File: tb/tb_chipid_fetch.sv
// Directed bench for chipid_fetch against a behavioural chip-ID slave with stall/zero/stuck controls.
module tb_chipid_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] chip_id;
  logic        chip_id_valid;
  logic        busy;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [31:0] lo_word, hi_word;
  int          stall_n, zero_n, stall_cnt, fetch_idx;
  bit          stuck;

  chipid_fetch_if bus ();

  chipid_fetch #(
    .AUTO_START   (1'b1),
    .WAIT_TIMEOUT (8),
    .RETRY_LIMIT  (2),
    .RETRY_DELAY  (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .bus           (bus.master),
    .chip_id       (chip_id),
    .chip_id_valid (chip_id_valid),
    .busy          (busy),
    .error         (error)
  );

  always #5 clk = ~clk;

  // Slave: stalls stall_n cycles per read, returns zero for fetches below zero_n.
  assign bus.m_waitrequest = bus.m_read && (stuck || (stall_cnt < stall_n));
  assign bus.m_readdata    = (fetch_idx < zero_n) ? 32'h0 : (bus.m_address ? hi_word : lo_word);

  initial begin
    stall_cnt = 0;
    fetch_idx = 0;
  end

  always @(posedge clk) begin
    if (bus.m_read && bus.m_waitrequest) begin
      stall_cnt <= stall_cnt + 1;
    end else begin
      stall_cnt <= 0;
      if (bus.m_read && bus.m_address) fetch_idx <= fetch_idx + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    lo_word = 32'hDEADBEEF;
    hi_word = 32'h0BADF00D;
    stall_n = 0;
    zero_n  = 0;
    stuck   = 1'b0;

    repeat (3) tick();
    chk1 ("rst_m_read",   bus.m_read,    1'b0);
    chk1 ("rst_m_addr",   bus.m_address, 1'b0);
    chk64("rst_chip_id",  chip_id,       64'h0);
    chk1 ("rst_valid",    chip_id_valid, 1'b0);
    chk1 ("rst_busy",     busy,          1'b0);
    chk1 ("rst_error",    error,         1'b0);

    // First cycle with reset low acts as start.
    reset = 1'b0;
    tick();
    chk1 ("auto_k1_busy", busy,          1'b1);
    chk1 ("auto_k1_read", bus.m_read,    1'b1);
    chk1 ("auto_k1_addr", bus.m_address, 1'b0);
    tick();
    chk1 ("auto_k2_addr", bus.m_address, 1'b1);
    tick();
    chk1 ("auto_valid",   chip_id_valid, 1'b1);
    chk64("auto_id",      chip_id,       64'h0BADF00D_DEADBEEF);
    chk1 ("auto_busy",    busy,          1'b0);

    // Zero-wait fetch; valid drops at once while chip_id holds the old value.
    repeat (3) tick();
    lo_word = 32'h89ABCDEF;
    hi_word = 32'h01234567;
    pulse_start();
    chk1 ("zw_k1_valid",  chip_id_valid, 1'b0);
    chk64("zw_k1_hold",   chip_id,       64'h0BADF00D_DEADBEEF);
    chk1 ("zw_k1_busy",   busy,          1'b1);
    chk1 ("zw_k1_addr",   bus.m_address, 1'b0);
    tick();
    chk1 ("zw_k2_busy",   busy,          1'b1);
    chk1 ("zw_k2_read",   bus.m_read,    1'b1);
    chk1 ("zw_k2_addr",   bus.m_address, 1'b1);
    tick();
    chk1 ("zw_k3_valid",  chip_id_valid, 1'b1);
    chk64("zw_k3_id",     chip_id,       64'h01234567_89ABCDEF);
    chk1 ("zw_k3_busy",   busy,          1'b0);
    chk1 ("zw_k3_read",   bus.m_read,    1'b0);

    // 5-cycle stall on each read; a start during the fetch is ignored.
    stall_n = 5;
    lo_word = 32'h11223344;
    hi_word = 32'h55667788;
    pulse_start();
    for (int k = 1; k <= 13; k++) begin
      if (k <= 6) begin
        chk1("st_lo_read", bus.m_read,    1'b1);
        chk1("st_lo_addr", bus.m_address, 1'b0);
      end else if (k <= 12) begin
        chk1("st_hi_read", bus.m_read,    1'b1);
        chk1("st_hi_addr", bus.m_address, 1'b1);
        chk1("st_hi_valid", chip_id_valid, 1'b0);
      end else begin
        chk1 ("st_valid", chip_id_valid, 1'b1);
        chk64("st_id",    chip_id,       64'h55667788_11223344);
        chk1 ("st_error", error,         1'b0);
      end
      start = (k == 3);
      if (k < 13) tick();
    end
    start   = 1'b0;
    stall_n = 0;
    tick();

    // waitrequest stuck high: m_read high for exactly 8 cycles, then abort.
    stuck = 1'b1;
    pulse_start();
    for (int k = 1; k <= 8; k++) begin
      chk1("to_read", bus.m_read, 1'b1);
      tick();
    end
    chk1("to_read_drop", bus.m_read,    1'b0);
    chk1("to_error",     error,         1'b1);
    chk1("to_busy",      busy,          1'b0);
    chk1("to_valid",     chip_id_valid, 1'b0);
    stuck = 1'b0;
    tick();
    chk1("to_error_sticky", error, 1'b1);

    // Nonzero low word with zero high word is a valid ID; start clears error.
    lo_word = 32'h00000001;
    hi_word = 32'h00000000;
    pulse_start();
    chk1("lo_only_err_clr", error, 1'b0);
    repeat (2) tick();
    chk1 ("lo_only_valid", chip_id_valid, 1'b1);
    chk64("lo_only_id",    chip_id,       64'h00000000_00000001);

`ifdef CHIPID_FETCH_ZERO_RETRY_EN
    // Two zero fetches then the ID: two DELAY visits of 4 cycles each.
    lo_word = 32'h89ABCDEF;
    hi_word = 32'h01234567;
    zero_n  = fetch_idx + 2;
    pulse_start();
    for (int k = 1; k <= 15; k++) begin
      if (k == 3 || k == 9) begin
        chk1("rt_delay_busy", busy,       1'b1);
        chk1("rt_delay_read", bus.m_read, 1'b0);
      end
      if (k == 14) chk1("rt_k14_valid", chip_id_valid, 1'b0);
      if (k == 15) begin
        chk1 ("rt_valid", chip_id_valid, 1'b1);
        chk64("rt_id",    chip_id,       64'h01234567_89ABCDEF);
        chk1 ("rt_error", error,         1'b0);
      end
      if (k < 15) tick();
    end

    // Always zero: FAIL after 3 fetches, then recovery with a good slave.
    zero_n = fetch_idx + 1000;
    pulse_start();
    repeat (13) tick();
    chk1("ex_k14_busy", busy, 1'b1);
    tick();
    chk1("ex_error", error,         1'b1);
    chk1("ex_valid", chip_id_valid, 1'b0);
    chk1("ex_busy",  busy,          1'b0);
    zero_n = 0;
    pulse_start();
    repeat (2) tick();
    chk1 ("rec_valid", chip_id_valid, 1'b1);
    chk1 ("rec_error", error,         1'b0);
    chk64("rec_id",    chip_id,       64'h01234567_89ABCDEF);
`else
    // Without retry an all-zero ID is accepted.
    zero_n = fetch_idx + 1000;
    pulse_start();
    repeat (2) tick();
    chk1 ("zero_valid", chip_id_valid, 1'b1);
    chk64("zero_id",    chip_id,       64'h0);
    chk1 ("zero_error", error,         1'b0);
    chk1 ("zero_busy",  busy,          1'b0);
    zero_n = 0;
`endif

    // Reset during RD_HI, then an automatic fetch after release.
    lo_word = 32'hCAFEBABE;
    hi_word = 32'h00C0FFEE;
    pulse_start();
    tick();
    chk1("mr_in_rd_hi", bus.m_address, 1'b1);
    reset = 1'b1;
    tick();
    chk1 ("mr_read",  bus.m_read,    1'b0);
    chk1 ("mr_addr",  bus.m_address, 1'b0);
    chk64("mr_id",    chip_id,       64'h0);
    chk1 ("mr_valid", chip_id_valid, 1'b0);
    chk1 ("mr_busy",  busy,          1'b0);
    chk1 ("mr_error", error,         1'b0);
    reset = 1'b0;
    repeat (3) tick();
    chk1 ("mr_auto_valid", chip_id_valid, 1'b1);
    chk64("mr_auto_id",    chip_id,       64'h00C0FFEE_CAFEBABE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
